// File: rtl/brp_resolve_ctrl.sv
// rtl/brp_resolve_ctrl.sv - branch prediction resolve queue, flush/redirect sequencer and accuracy counters
module brp_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic             push_pred,
  input  logic [31:0]      push_target,
  input  logic [31:0]      push_alt,
  output logic             push_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_correct,
  output logic             err_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]    state;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          q_pred [DEPTH];
  logic [31:0]   q_alt  [DEPTH];

  logic do_push;
  logic do_res;
  logic mispred;

  // The predicted target only matters to IF; recovery needs the alternate PC alone.
  logic unused_target;
  assign unused_target = ^push_target;

  assign push_ready = !rst && (state == S_RUN) && (count < CW'(DEPTH));
  assign do_push    = push_valid && push_ready;
  assign do_res     = res_valid && (state == S_RUN) && (count != '0);
  assign mispred    = do_res && (q_pred[rd_ptr] != res_taken);

  always_ff @(posedge clk) begin
    if (do_push) begin
      q_pred[wr_ptr] <= push_pred;
      q_alt[wr_ptr]  <= push_alt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_RUN;
      flush_cnt      <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cnt_total      <= '0;
      cnt_correct    <= '0;
      err_underflow  <= 1'b0;
    end else begin
      upd_valid      <= do_res;
      redirect_valid <= mispred;
      if (do_res) begin
        upd_taken <= res_taken;
        if (cnt_total != '1) cnt_total <= cnt_total + CNT_W'(1);
        if (!mispred && cnt_correct != '1) cnt_correct <= cnt_correct + CNT_W'(1);
      end
      if (mispred) redirect_pc <= q_alt[rd_ptr];
      if (res_valid && state == S_RUN && count == '0) err_underflow <= 1'b1;

      case (state)
        S_RUN: begin
          if (mispred) begin
            // Everything behind the mispredicted head is wrong-path, including a same-cycle push.
            state     <= S_FLUSH;
            flush     <= 1'b1;
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_res);
            count  <= count + CW'(do_push) - CW'(do_res);
          end
        end
        default: begin
          if (flush_cnt == '0) begin
            state <= S_RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brp_resolve_ctrl.sv
// tb/tb_brp_resolve_ctrl.sv - directed self-checking bench for brp_resolve_ctrl
module tb_brp_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_pred, res_valid, res_taken;
  logic [31:0] push_target, push_alt;

  logic        push_ready, upd_valid, upd_taken, flush, redirect_valid, err_underflow;
  logic [31:0] redirect_pc, cnt_total, cnt_correct;

  logic        s_push_ready, s_upd_valid, s_upd_taken, s_flush, s_redirect_valid, s_err_underflow;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_cnt_total, s_cnt_correct;

  int total = 0;
  int bad   = 0;
  int exp_total, exp_correct;
  bit mq[$];
  bit exp_head;
  bit pat [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit fill [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  brp_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pred(push_pred), .push_target(push_target), .push_alt(push_alt),
    .push_ready(push_ready), .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cnt_total(cnt_total), .cnt_correct(cnt_correct), .err_underflow(err_underflow)
  );

  brp_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pred(push_pred), .push_target(push_target), .push_alt(push_alt),
    .push_ready(s_push_ready), .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(s_upd_valid), .upd_taken(s_upd_taken), .flush(s_flush),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .cnt_total(s_cnt_total), .cnt_correct(s_cnt_correct), .err_underflow(s_err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; push_valid = 0; push_pred = 0; push_target = 0; push_alt = 0;
    res_valid = 0; res_taken = 0;
    cyc(); cyc();
    check("rst_push_ready", push_ready, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_total", cnt_total, 0);
    check("rst_correct", cnt_correct, 0);
    check("rst_err", err_underflow, 0);
    rst = 1'b0;
    #1;
    check("run_push_ready", push_ready, 1);

    // single correct prediction
    push_valid = 1; push_pred = 1; push_target = 32'h100; push_alt = 32'h0C4;
    cyc();
    push_valid = 0; res_valid = 1; res_taken = 1;
    cyc();
    res_valid = 0;
    check("t1_upd_valid", upd_valid, 1);
    check("t1_upd_taken", upd_taken, 1);
    check("t1_flush", flush, 0);
    check("t1_redirect", redirect_valid, 0);
    check("t1_total", cnt_total, 1);
    check("t1_correct", cnt_correct, 1);
    cyc();
    check("t1_upd_pulse", upd_valid, 0);

    // mispredict on the oldest of three, with a wrong-path push in the same cycle
    for (int i = 0; i < 3; i++) begin
      push_valid = 1; push_pred = 1; push_alt = 32'hA0 + 32'(i) * 32'h10;
      cyc();
    end
    push_valid = 1; push_pred = 1; push_alt = 32'hEE;
    res_valid = 1; res_taken = 0;
    cyc();
    push_valid = 0; res_valid = 0;
    check("t2_redirect_valid", redirect_valid, 1);
    check("t2_redirect_pc", redirect_pc, 32'hA0);
    check("t2_flush1", flush, 1);
    check("t2_ready1", push_ready, 0);
    check("t2_upd_taken", upd_taken, 0);
    check("t2_total", cnt_total, 2);
    check("t2_correct", cnt_correct, 1);
    res_valid = 1; res_taken = 1;
    cyc();
    check("t2_redirect_pulse", redirect_valid, 0);
    check("t2_flush2", flush, 1);
    check("t2_ready2", push_ready, 0);
    check("t2_flush_ignores_res", upd_valid, 0);
    res_valid = 0;
    cyc();
    check("t2_flush_end", flush, 0);
    check("t2_ready_back", push_ready, 1);
    check("t2_total_held", cnt_total, 2);
    exp_total = 2; exp_correct = 1;

    // fill to full; an empty queue must take exactly four
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_pred = fill[i]; push_alt = 32'h200 + 32'(i);
      mq.push_back(fill[i]);
      cyc();
      if (i == 2) check("t3_ready_at3", push_ready, 1);
    end
    check("t3_full", push_ready, 0);
    push_valid = 1; push_pred = 0;
    res_valid = 1; res_taken = mq[0];
    exp_head = mq.pop_front();
    cyc();
    exp_total++; exp_correct++;
    check("t3_full_pop_upd", upd_valid, 1);
    check("t3_full_pop_taken", upd_taken, exp_head);
    check("t3_push_dropped_ready", push_ready, 1);
    for (int i = 0; i < 8; i++) begin
      push_valid = 1; push_pred = pat[i];
      res_valid = 1; res_taken = mq[0];
      mq.push_back(pat[i]);
      exp_head = mq.pop_front();
      cyc();
      exp_total++; exp_correct++;
      check("t3_pair_taken", upd_taken, exp_head);
      check("t3_pair_flush", flush, 0);
      check("t3_pair_correct", cnt_correct, exp_correct);
    end
    push_valid = 0;
    while (mq.size() > 0) begin
      res_valid = 1; res_taken = mq[0];
      exp_head = mq.pop_front();
      cyc();
      exp_total++; exp_correct++;
      check("t3_drain_taken", upd_taken, exp_head);
    end
    check("t3_total", cnt_total, exp_total);
    check("t3_correct", cnt_correct, exp_correct);

    // resolve with nothing queued
    res_valid = 1; res_taken = 1;
    cyc();
    res_valid = 0;
    check("t4_no_upd", upd_valid, 0);
    check("t4_err", err_underflow, 1);
    check("t4_total_held", cnt_total, exp_total);
    cyc(); cyc(); cyc();
    check("t4_err_sticky", err_underflow, 1);

    // reset during the second flush cycle
    push_valid = 1; push_pred = 1; push_alt = 32'h55;
    cyc();
    push_valid = 0; res_valid = 1; res_taken = 0;
    cyc();
    res_valid = 0;
    check("t5_flush1", flush, 1);
    cyc();
    check("t5_flush2", flush, 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    check("t5_flush_cleared", flush, 0);
    check("t5_ready", push_ready, 1);
    check("t5_total", cnt_total, 0);
    check("t5_correct", cnt_correct, 0);
    check("t5_err", err_underflow, 0);

    // saturation on the narrow-counter instance
    push_valid = 1; push_pred = 1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      push_valid = 1; push_pred = 1; res_valid = 1; res_taken = 1;
      cyc();
    end
    push_valid = 0; res_valid = 0;
    check("t6_small_total", s_cnt_total, 15);
    check("t6_small_correct", s_cnt_correct, 15);
    check("t6_wide_total", cnt_total, 20);
    check("t6_wide_correct", cnt_correct, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
